// File: rtl/control_sequencer_pkg.sv
// Shared encodings for the multi-cycle control sequencer: state, PC source and branch op.
// Pure definitions; no latency, no backpressure.
// Imported by control_sequencer and ctrl_seq_counters.
package control_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_t;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_EQ   = 2'b01;
    localparam logic [1:0] BR_NE   = 2'b10;
    localparam logic [1:0] BR_JAL  = 2'b11;

    function automatic logic is_cond_branch(input logic [1:0] op);
        return (op == BR_EQ) || (op == BR_NE);
    endfunction

endpackage

// File: rtl/ctrl_seq_counters.sv
// Retired-instruction counter plus optional perf counters (CTRL_SEQ_PERF_CNT_EN).
// Latency: count visible the cycle after the qualifying event; never stalls.
// Backpressure: none; all counters wrap modulo 2^CNT_W.
module ctrl_seq_counters
    import control_sequencer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire,
`ifdef CTRL_SEQ_PERF_CNT_EN
    input  logic             active,
    input  logic             stall,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count,
`endif
    output logic [CNT_W-1:0] instr_retired
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_retired <= '0;
        end else if (retire) begin
            instr_retired <= instr_retired + CNT_W'(1);
        end
    end

`ifdef CTRL_SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count <= '0;
            stall_count <= '0;
        end else begin
            if (active) cycle_count <= cycle_count + CNT_W'(1);
            if (stall)  stall_count <= stall_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/control_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer turning decoder control words into timed strobes.
// Latency: branch 3, ALU/store/JAL 4, load 5 cycles plus one per memory wait cycle.
// Backpressure: holds in FETCH/MEM until imem_ready/dmem_ready; perf counters under CTRL_SEQ_PERF_CNT_EN.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             ctrl_valid,
    input  logic             ctrl_reg_write,
    input  logic             ctrl_mem_read,
    input  logic             ctrl_mem_write,
    input  logic [1:0]       ctrl_branch_op,
    input  logic             branch_cond,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_write,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_write_en,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic [2:0]       state,
    output logic             halted,
`ifdef CTRL_SEQ_PERF_CNT_EN
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count,
`endif
    output logic [CNT_W-1:0] instr_retired
);

    state_t state_q;
    state_t state_nxt;
    logic   retire;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        reg_write_en = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_SEQ;
        retire       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_write  = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_nxt = ctrl_valid ? ST_EXEC : ST_HALT;
            end
            ST_EXEC: begin
                if (ctrl_mem_read || ctrl_mem_write) begin
                    state_nxt = ST_MEM;
                end else if (ctrl_branch_op == BR_JAL || ctrl_reg_write) begin
                    state_nxt = ST_WB;
                end else begin
                    pc_write = 1'b1;
                    retire   = 1'b1;
                    if (is_cond_branch(ctrl_branch_op) && branch_cond) pc_src = PC_BR;
                end
            end
            ST_MEM: begin
                // Write wins when both read and write are set: that is the store encoding.
                dmem_req = 1'b1;
                dmem_we  = ctrl_mem_write;
                if (dmem_ready) begin
                    if (ctrl_mem_write) begin
                        pc_write = 1'b1;
                        retire   = 1'b1;
                    end else begin
                        state_nxt = ST_WB;
                    end
                end
            end
            ST_WB: begin
                reg_write_en = 1'b1;
                pc_write     = 1'b1;
                retire       = 1'b1;
                if (ctrl_branch_op == BR_JAL) pc_src = PC_JMP;
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // run is only looked at on an instruction boundary.
        if (retire) state_nxt = run ? ST_FETCH : ST_IDLE;
    end

    assign state  = state_q;
    assign halted = (state_q == ST_HALT);

`ifdef CTRL_SEQ_PERF_CNT_EN
    logic active;
    logic stall;

    assign active = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign stall  = ((state_q == ST_FETCH) && !imem_ready) ||
                    ((state_q == ST_MEM)   && !dmem_ready);
`endif

    ctrl_seq_counters #(
        .CNT_W (CNT_W)
    ) u_counters (
        .clk           (clk),
        .rst           (rst),
        .retire        (retire),
`ifdef CTRL_SEQ_PERF_CNT_EN
        .active        (active),
        .stall         (stall),
        .cycle_count   (cycle_count),
        .stall_count   (stall_count),
`endif
        .instr_retired (instr_retired)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks ALU, load, store, branch, JAL, run-drop,
// fetch wait, illegal-opcode halt and asynchronous reset, with hand-computed expectations.
module tb_control_sequencer;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             run;
    logic             ctrl_valid;
    logic             ctrl_reg_write;
    logic             ctrl_mem_read;
    logic             ctrl_mem_write;
    logic [1:0]       ctrl_branch_op;
    logic             branch_cond;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             ir_write;
    logic             dmem_req;
    logic             dmem_we;
    logic             reg_write_en;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic [2:0]       state;
    logic             halted;
    logic [CNT_W-1:0] instr_retired;
`ifdef CTRL_SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] stall_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    control_sequencer #(.CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .run            (run),
        .ctrl_valid     (ctrl_valid),
        .ctrl_reg_write (ctrl_reg_write),
        .ctrl_mem_read  (ctrl_mem_read),
        .ctrl_mem_write (ctrl_mem_write),
        .ctrl_branch_op (ctrl_branch_op),
        .branch_cond    (branch_cond),
        .imem_ready     (imem_ready),
        .dmem_ready     (dmem_ready),
        .imem_req       (imem_req),
        .ir_write       (ir_write),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .reg_write_en   (reg_write_en),
        .pc_write       (pc_write),
        .pc_src         (pc_src),
        .state          (state),
        .halted         (halted),
`ifdef CTRL_SEQ_PERF_CNT_EN
        .cycle_count    (cycle_count),
        .stall_count    (stall_count),
`endif
        .instr_retired  (instr_retired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 2ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ctrl(input logic v, input logic rw, input logic mr, input logic mw,
                            input logic [1:0] br, input logic bc);
        ctrl_valid     = v;
        ctrl_reg_write = rw;
        ctrl_mem_read  = mr;
        ctrl_mem_write = mw;
        ctrl_branch_op = br;
        branch_cond    = bc;
    endtask

    initial begin
        rst = 1'b0;
        run = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_retired", instr_retired, 32'd0);
        chk("rst_pc_src", 32'(pc_src), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd0);

        tick(); tick();
        rst = 1'b1;
        tick();
        chk("idle_hold", 32'(state), 32'd0);

        // ALU op: FETCH, DECODE, EXEC, WB
        run = 1'b1;
        tick();
        chk("alu_fetch", 32'(state), 32'd1);
        chk("alu_ir_write", 32'(ir_write), 32'd1);
        chk("alu_imem_req", 32'(imem_req), 32'd1);
        tick();
        chk("alu_decode", 32'(state), 32'd2);
        tick();
        chk("alu_exec", 32'(state), 32'd3);
        chk("alu_exec_pcw", 32'(pc_write), 32'd0);
        tick();
        chk("alu_wb", 32'(state), 32'd5);
        chk("alu_wb_rwe", 32'(reg_write_en), 32'd1);
        chk("alu_wb_pcw", 32'(pc_write), 32'd1);
        chk("alu_wb_pcsrc", 32'(pc_src), 32'd0);
        chk("alu_wb_retired", instr_retired, 32'd0);
        tick();
        chk("alu_next_fetch", 32'(state), 32'd1);
        chk("alu_retired", instr_retired, 32'd1);

        // Load with two dmem wait cycles
        set_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        dmem_ready = 1'b0;
        tick();
        chk("ld_decode", 32'(state), 32'd2);
        chk("ld_decode_dreq", 32'(dmem_req), 32'd0);
        tick();
        chk("ld_exec", 32'(state), 32'd3);
        tick();
        chk("ld_mem1", 32'(state), 32'd4);
        chk("ld_mem1_dreq", 32'(dmem_req), 32'd1);
        chk("ld_mem1_dwe", 32'(dmem_we), 32'd0);
        chk("ld_mem1_pcw", 32'(pc_write), 32'd0);
        tick();
        chk("ld_mem2", 32'(state), 32'd4);
        chk("ld_mem2_dreq", 32'(dmem_req), 32'd1);
        tick();
        dmem_ready = 1'b1;
        #1;
        chk("ld_mem3", 32'(state), 32'd4);
        chk("ld_mem3_dreq", 32'(dmem_req), 32'd1);
        chk("ld_mem3_rwe", 32'(reg_write_en), 32'd0);
        tick();
        chk("ld_wb", 32'(state), 32'd5);
        chk("ld_wb_rwe", 32'(reg_write_en), 32'd1);
        chk("ld_wb_dreq", 32'(dmem_req), 32'd0);
        tick();
        chk("ld_next_fetch", 32'(state), 32'd1);
        chk("ld_retired", instr_retired, 32'd2);

        // Store: read+write set, write dominates
        set_ctrl(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0);
        tick(); tick(); tick();
        chk("st_mem", 32'(state), 32'd4);
        chk("st_dwe", 32'(dmem_we), 32'd1);
        chk("st_pcw", 32'(pc_write), 32'd1);
        chk("st_pcsrc", 32'(pc_src), 32'd0);
        chk("st_rwe", 32'(reg_write_en), 32'd0);
        tick();
        chk("st_next_fetch", 32'(state), 32'd1);
        chk("st_retired", instr_retired, 32'd3);

        // Taken conditional branch
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1);
        tick(); tick();
        chk("br_t_exec", 32'(state), 32'd3);
        chk("br_t_pcw", 32'(pc_write), 32'd1);
        chk("br_t_pcsrc", 32'(pc_src), 32'd1);
        tick();
        chk("br_t_next_fetch", 32'(state), 32'd1);
        chk("br_t_retired", instr_retired, 32'd4);

        // Not-taken conditional branch
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0);
        tick(); tick();
        chk("br_nt_pcw", 32'(pc_write), 32'd1);
        chk("br_nt_pcsrc", 32'(pc_src), 32'd0);
        tick();
        chk("br_nt_retired", instr_retired, 32'd5);

        // Jump-and-link goes through WB even with reg_write=0
        set_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0);
        tick(); tick();
        chk("jal_exec_pcw", 32'(pc_write), 32'd0);
        tick();
        chk("jal_wb", 32'(state), 32'd5);
        chk("jal_wb_rwe", 32'(reg_write_en), 32'd1);
        chk("jal_wb_pcsrc", 32'(pc_src), 32'd2);
        tick();
        chk("jal_retired", instr_retired, 32'd6);

        // run dropped during EXEC of a load: completes, then IDLE
        set_ctrl(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0);
        tick(); tick();
        run = 1'b0;
        tick();
        chk("rd_mem", 32'(state), 32'd4);
        tick();
        chk("rd_wb_rwe", 32'(reg_write_en), 32'd1);
        tick();
        chk("rd_idle", 32'(state), 32'd0);
        chk("rd_retired", instr_retired, 32'd7);
        tick();
        chk("rd_idle_hold", 32'(state), 32'd0);
        chk("rd_idle_imem_req", 32'(imem_req), 32'd0);

        // Fetch with three imem wait cycles, then an illegal opcode
        set_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        imem_ready = 1'b0;
        run = 1'b1;
        tick();
        chk("fw_fetch1_ir", 32'(ir_write), 32'd0);
        chk("fw_fetch1_req", 32'(imem_req), 32'd1);
        tick();
        tick();
        chk("fw_fetch3", 32'(state), 32'd1);
        tick();
        imem_ready = 1'b1;
        #1;
        chk("fw_fetch4_ir", 32'(ir_write), 32'd1);
        tick();
        chk("fw_decode", 32'(state), 32'd2);
`ifdef CTRL_SEQ_PERF_CNT_EN
        // stalls: 2 from the load + 3 here; active cycles: 4+7+4+3+3+4+5+4
        chk("perf_stall", stall_count, 32'd5);
        chk("perf_cycle", cycle_count, 32'd34);
`endif
        tick();
        chk("halt_state", 32'(state), 32'd6);
        chk("halt_flag", 32'(halted), 32'd1);
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        chk("halt_sticky", 32'(state), 32'd6);
        chk("halt_imem_req", 32'(imem_req), 32'd0);
        chk("halt_retired", instr_retired, 32'd7);

        rst = 1'b0;
        #1;
        chk("halt_rst_state", 32'(state), 32'd0);
        chk("halt_rst_flag", 32'(halted), 32'd0);
        chk("halt_rst_retired", instr_retired, 32'd0);

        // Reset asserted in the WB cycle of an ALU op kills the write at once
        tick();
        rst = 1'b1;
        set_ctrl(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
        tick(); tick(); tick(); tick();
        chk("mid_wb_rwe", 32'(reg_write_en), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_rwe", 32'(reg_write_en), 32'd0);
        chk("mid_rst_pcw", 32'(pc_write), 32'd0);
        chk("mid_rst_state", 32'(state), 32'd0);
        tick();
        chk("mid_rst_retired", instr_retired, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle execution sequencer for the RISC core; consumes the per-opcode control word from the decode stage.
- Turns that control word into timed strobes: IR load, PC update, register-file write, and instruction/data memory request/ready handshakes.
- Sits between the decoder and the datapath/memories. Replaces single-cycle "all controls live at once" operation with a FETCH/DECODE/EXEC/MEM/WB sequence.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (and the optional perf counters).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous reset, active-low.
- run  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- ctrl_valid  in  1  decoded opcode is legal (0 for the decoder default case).
- ctrl_reg_write  in  1  decoder reg_write.
- ctrl_mem_read  in  1  decoder memory_read.
- ctrl_mem_write  in  1  decoder memory_write.
- ctrl_branch_op  in  2  decoder branchOP: 00 none, 01/10 conditional, 11 jump-and-link.
- branch_cond  in  1  condition for the current conditional branch is met (from the ALU flags).
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory access complete.
- imem_req  out  1  fetch request.
- ir_write  out  1  load the instruction register.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write enable; valid only while dmem_req=1.
- reg_write_en  out  1  register-file write strobe.
- pc_write  out  1  PC update strobe.
- pc_src  out  2  PC source: 00 PC+4, 01 branch target, 10 jump target.
- state  out  3  current state encoding.
- halted  out  1  illegal opcode trapped.
- instr_retired  out  CNT_W  retired-instruction count.

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. State register is asynchronously reset to IDLE.
- All strobes are Moore/combinational decodes of state plus inputs. All are 0 in IDLE and HALT.
- Reset values: halted=0, instr_retired=0, pc_src=00.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH: assert imem_req. Stay in FETCH while imem_ready=0. When imem_ready=1: ir_write=1 that same cycle, then go to DECODE.
- DECODE: single cycle.
  - ctrl_valid=0: go to HALT and set halted=1.
  - Otherwise go to EXEC.
- EXEC: single cycle; exit is chosen by priority:
  1. ctrl_mem_read=1 or ctrl_mem_write=1: go to MEM.
  2. ctrl_branch_op=11: go to WB (link write).
  3. ctrl_reg_write=1: go to WB.
  4. Otherwise (branch or no-op): pc_write=1 and retire this cycle.
     - pc_src=01 if ctrl_branch_op is 01/10 and branch_cond=1; else 00.
- MEM: assert dmem_req.
  - dmem_we = ctrl_mem_write. Write dominates when both read and write are set (store encoding).
  - Hold until dmem_ready=1, then:
    - Store: pc_write=1, pc_src=00, retire.
    - Load: go to WB.
- WB: reg_write_en=1 and pc_write=1 for one cycle, then retire.
  - pc_src=10 for jump-and-link, else 00.
- Retire: instr_retired increments by 1 (wraps modulo 2^CNT_W).
  - Next state is FETCH if run=1, else IDLE.
  - run is sampled only at retire; deasserting run mid-instruction completes that instruction.
- Latency with zero-wait memories (imem_ready/dmem_ready tied 1):
  - ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Jump-and-link: 4 cycles.
  - Each wait cycle adds 1.
- HALT is sticky. Only reset exits it; run is ignored.
- A ready input that is high outside its request state is ignored.
- Reset asserted mid-operation: immediate return to IDLE, strobes drop asynchronously, counters clear. No partial write completes.

Optional Feature:
- Macro: CTRL_SEQ_PERF_CNT_EN.
- Defined: adds outputs cycle_count (CNT_W) and stall_count (CNT_W).
  - cycle_count increments every cycle state != IDLE/HALT.
  - stall_count increments every cycle in FETCH with imem_ready=0 or in MEM with dmem_ready=0.
  - Both reset to 0 and wrap.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package: state encodings (IDLE..HALT), pc_src encodings (PC_SEQ=00, PC_BR=01, PC_JMP=10), branchOP encodings (BR_NONE, BR_EQ=01, BR_NE=10, BR_JAL=11).
- No sub-module required. Optionally, the counter block (instr_retired plus perf counters) can be a small sub-module, ctrl_seq_counters.

Test Plan:
- ALU op (reg_write=1, others 0), memories zero-wait, run=1 → state sequence 1,2,3,5. reg_write_en and pc_write both high in the WB cycle, pc_src=00; instr_retired=1 after 4 cycles.
- Load (mem_read=1, reg_write=1), dmem_ready low for 2 cycles → dmem_req high 3 cycles with dmem_we=0, then WB. Total 7 cycles.
- Store (mem_read=1, mem_write=1, reg_write=0) → dmem_we=1 during MEM; pc_write in the MEM exit cycle; reg_write_en never asserted.
- Branch branchOP=01: branch_cond=1 → pc_src=01 with pc_write in EXEC, 3 cycles. branch_cond=0 → pc_src=00. branchOP=11 → WB with reg_write_en=1, pc_src=10.
- ctrl_valid=0 at DECODE → HALT, halted=1; run toggled stays in HALT. rst low → IDLE, halted=0, instr_retired=0.
- run dropped during EXEC of a load → instruction completes through WB, then IDLE. With CTRL_SEQ_PERF_CNT_EN and imem_ready delayed 3 cycles on one fetch → stall_count=3.
